or4_sweep_gen: RTL and testbench
================================

# or4_sweep_gen

Sweep generator and response checker that sits on both sides of the `four_or` gate. It drives the gate's four inputs through all 16 input combinations, holding each for a programmable number of clocks, with outD toggling fastest and outA slowest. It samples the gate's output and counts mismatches against the expected OR. It runs either one sweep per start request or continuously, so the gate can be exercised on-board without a simulator testbench.

## Interface
Parameters:
- `DIV`, default 4: clock cycles each pattern is held. Legal range 1..255.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: sweep request. Sampled only in IDLE or DONE.
- `continuous`  in  1: 1 = wrap 15→0 and keep sweeping. 0 = stop after pattern 15.
- `sumIn`  in  1: output of the gate under test (`four_or.outE`).
- `outA`, `outB`, `outC`, `outD`  out  1 each: drive `four_or.inA`..`inD`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: high in DONE until the next start or reset.
- `errCount`  out  8: mismatch count for the current run. Saturates at 255.

## Operation
- Internal state: FSM `{IDLE, RUN, DONE}`, 4-bit pattern counter `pat`, and divider counter `div` of width ceil(log2(DIV)), minimum 1 bit.
- Pattern mapping: `{outA,outB,outC,outD} = pat` (outA is the MSB) in RUN. All four outputs are 0 in IDLE and DONE.
- Reset (`rst`=1 at an edge):
  - state→IDLE, `pat`=0, `div`=0.
  - outA..outD=0, `busy`=0, `done`=0, `errCount`=0.
  - Reset has priority over every other input, including mid-RUN.
- IDLE/DONE + `start`=1: state→RUN, `pat`=0, `div`=0, `errCount`=0, `done`=0, `busy`=1.
- RUN behaviour:
  - `start` is ignored.
  - `div` increments each cycle.
  - On the last hold cycle (`div`==DIV-1), `sumIn` is compared with the expected value `|pat`. On mismatch, `errCount` increments, saturating at 255.
  - At that same edge, `div`→0 and `pat` advances.
- End of pattern 15 (`pat`==15 and `div`==DIV-1):
  - `continuous`=1: `pat`→0 and the FSM stays in RUN. There is no gap cycle, and `errCount` is not cleared.
  - `continuous`=0: state→DONE, `busy`→0, `done`→1, outputs→0.
- `continuous` is sampled only at the end-of-sweep edge. Changing it mid-sweep affects only the decision at the next end-of-sweep edge.
- DONE holds `done`=1 and freezes `errCount` until `start` or `rst`.
- `sumIn` is treated as combinational from outA..outD. It is sampled only on the last hold cycle, which gives DIV-1 cycles of settling. With DIV=1 it is sampled in the same cycle the pattern is driven.

## Timing
- Let edge k be the edge at which `start`=1 is sampled in IDLE or DONE.
  - After edge k: `busy`=1 and pattern 0 is on the outputs.
  - Pattern n is driven for cycles k+1+n·DIV through k+(n+1)·DIV.
  - Pattern n is checked at edge k+(n+1)·DIV.
- One-shot sweep:
  - After edge k+16·DIV: `busy`=0, `done`=1, outputs 0.
  - The final `errCount` is visible in the same cycle `done` rises.
- Period of each output in RUN:
  - outD: 2·DIV
  - outC: 4·DIV
  - outB: 8·DIV
  - outA: 16·DIV
- `errCount` changes only at check edges.
- There is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random other inputs → all outputs 0 and `errCount`=0. Then `start` with `rst`=1 → state remains IDLE.
- **Good gate, DIV=4, one-shot:** pulse `start` → outputs step through 0..15, each held 4 cycles. `done`=1 exactly 64 cycles after the start edge, `errCount`=0, `busy` high for 64 cycles.
- **sumIn stuck at 0:** one-shot → `errCount`=15 at done.
- **sumIn stuck at 1:** one-shot → `errCount`=1 (pattern 0 only).
- **Continuous with sumIn stuck at 0:** run 20 sweeps → `errCount` saturates at 255 (not 300) and the 15→0 wrap has no gap cycle. Deassert `continuous` at pattern 5 → `done` rises at the end of that same sweep.
- **Mid-run events:** pulse `start` during RUN at pattern 3 → no restart and timing unchanged. Assert `rst` at pattern 7 → next cycle outputs 0, `busy`=0, `errCount`=0, and a new `start` begins again at pattern 0. With DIV=1 → a full sweep takes 16 cycles and a good gate gives `errCount`=0.

Source files
------------

// File: rtl/or4_sweep_gen.sv
// Sweep generator and response checker wrapped around a four-input OR gate.
// Drives {outA,outB,outC,outD} through patterns 0..15, holding each pattern for
// DIV clocks. On the last hold cycle of each pattern it compares the gate
// output sumIn against the expected OR and counts mismatches, saturating at 255.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - sweep request, honoured only in IDLE or DONE
//   continuous      - 1: wrap 15->0 and keep sweeping; 0: stop after pattern 15
//   sumIn           - output of the gate under test
//   outA..outD      - gate stimulus (outA is the MSB of the pattern)
//   busy, done      - status flags
//   errCount        - mismatch count for the current run
// Every output decodes registered state only, so no input reaches an output
// combinationally.
module or4_sweep_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       sumIn,
  output logic       outA,
  output logic       outB,
  output logic       outC,
  output logic       outD,
  output logic       busy,
  output logic       done,
  output logic [7:0] errCount
);

  // The divider needs at least one bit, even when DIV is 1.
  localparam int unsigned     DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    pat_q,   pat_d;
  logic [DW-1:0] div_q,   div_d;
  logic [7:0]    err_q,   err_d;

  logic last_hold;
  logic expected;

  assign last_hold = (div_q == DIV_LAST);
  assign expected  = |pat_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    div_d   = div_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pat_d   = 4'd0;
          div_d   = '0;
          err_d   = 8'd0;
        end
      end

      RUN: begin
        div_d = div_q + 1'b1;
        if (last_hold) begin
          div_d = '0;
          if ((sumIn != expected) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
          // Pattern 15 naturally wraps to 0, which is also what a continuous
          // sweep needs; a one-shot sweep leaves RUN at the same edge.
          pat_d = pat_q + 4'd1;
          if ((pat_q == 4'hF) && !continuous) begin
            state_d = DONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        pat_d   = 4'd0;
        div_d   = '0;
        err_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= 4'd0;
      div_q   <= '0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  assign {outA, outB, outC, outD} = (state_q == RUN) ? pat_q : 4'd0;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign errCount = err_q;

endmodule

// File: tb/tb_or4_sweep_gen.sv
// Directed bench for or4_sweep_gen: one instance with DIV=4 and one with DIV=1.
// The DIV=4 gate model can be a correct OR, stuck at 0, or stuck at 1.
// All checks sample on the falling edge, halfway between active edges.
module tb_or4_sweep_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       sum4;
  logic [1:0] mode;
  logic       a4, b4, c4, d4, busy4, done4;
  logic [7:0] err4;

  logic       start1;
  logic       cont1;
  logic       sum1;
  logic       a1, b1, c1, d1, busy1, done1;
  logic [7:0] err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate model: 0 = correct OR, 1 = stuck at 0, 2 = stuck at 1.
  assign sum4 = (mode == 2'd0) ? (a4 | b4 | c4 | d4) : (mode == 2'd2);
  assign sum1 = a1 | b1 | c1 | d1;

  or4_sweep_gen #(.DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .continuous(cont), .sumIn(sum4),
    .outA(a4), .outB(b4), .outC(c4), .outD(d4),
    .busy(busy4), .done(done4), .errCount(err4)
  );

  or4_sweep_gen #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .continuous(cont1), .sumIn(sum1),
    .outA(a1), .outB(b1), .outC(c1), .outD(d1),
    .busy(busy1), .done(done1), .errCount(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Pulse start for one active edge; returns in the first cycle after it.
  task automatic pulse_start4();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One-shot DIV=4 sweep with the pattern/busy timeline and the final count.
  task automatic one_shot4(input string tag, input int exp_err);
    pulse_start4();
    for (int j = 1; j <= 64; j++) begin
      chk({tag, "_pat"},  {28'd0, a4, b4, c4, d4}, (j - 1) / 4);
      chk({tag, "_busy"}, {31'd0, busy4}, 1);
      chk({tag, "_done"}, {31'd0, done4}, 0);
      @(negedge clk);
    end
    chk({tag, "_end_done"}, {31'd0, done4}, 1);
    chk({tag, "_end_busy"}, {31'd0, busy4}, 0);
    chk({tag, "_end_pat"},  {28'd0, a4, b4, c4, d4}, 0);
    chk({tag, "_end_err"},  {24'd0, err4}, exp_err);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    cont   = 1'b0;
    mode   = 2'd0;
    start1 = 1'b0;
    cont1  = 1'b0;

    // Reset with random other inputs.
    for (int i = 0; i < 2; i++) begin
      start  = 1'($urandom);
      cont   = 1'($urandom);
      mode   = 2'($urandom_range(0, 2));
      start1 = 1'($urandom);
      @(negedge clk);
    end
    chk("rst_pat4",  {28'd0, a4, b4, c4, d4}, 0);
    chk("rst_busy4", {31'd0, busy4}, 0);
    chk("rst_done4", {31'd0, done4}, 0);
    chk("rst_err4",  {24'd0, err4}, 0);
    chk("rst_busy1", {31'd0, busy1}, 0);

    // start while rst is high must not leave IDLE.
    start = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy4}, 0);
    chk("rst_start_pat",  {28'd0, a4, b4, c4, d4}, 0);
    rst    = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    cont   = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy4}, 0);

    // Good gate, stuck-at-0, stuck-at-1.
    mode = 2'd0;
    one_shot4("good", 0);
    mode = 2'd1;
    one_shot4("sa0", 15);
    mode = 2'd2;
    one_shot4("sa1", 1);

    // Continuous sweeps with a stuck-at-0 gate; stop requested mid sweep 20.
    mode = 2'd1;
    cont = 1'b1;
    pulse_start4();
    for (int j = 1; j <= 1280; j++) begin
      chk("cont_busy", {31'd0, busy4}, 1);
      if (j == 64)   chk("cont_pat15", {28'd0, a4, b4, c4, d4}, 15);
      if (j == 65)   chk("cont_wrap0", {28'd0, a4, b4, c4, d4}, 0);
      if (j == 1025) chk("cont_err16", {24'd0, err4}, 240);
      if (j == 19 * 64 + 21) cont = 1'b0;
      @(negedge clk);
    end
    chk("cont_done", {31'd0, done4}, 1);
    chk("cont_sat",  {24'd0, err4}, 255);

    // start pulse during RUN is ignored.
    mode = 2'd0;
    pulse_start4();
    for (int j = 1; j <= 64; j++) begin
      if (j == 13) start = 1'b1;
      if (j == 14) start = 1'b0;
      chk("mid_pat",  {28'd0, a4, b4, c4, d4}, (j - 1) / 4);
      chk("mid_busy", {31'd0, busy4}, 1);
      @(negedge clk);
    end
    chk("mid_done", {31'd0, done4}, 1);

    // Reset at pattern 7 of a stuck-at-0 run, then restart.
    mode = 2'd1;
    pulse_start4();
    for (int j = 1; j < 29; j++) @(negedge clk);
    chk("pre_rst_pat", {28'd0, a4, b4, c4, d4}, 7);
    chk("pre_rst_err", {24'd0, err4}, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_pat",  {28'd0, a4, b4, c4, d4}, 0);
    chk("mrst_busy", {31'd0, busy4}, 0);
    chk("mrst_done", {31'd0, done4}, 0);
    chk("mrst_err",  {24'd0, err4}, 0);
    pulse_start4();
    chk("restart_busy", {31'd0, busy4}, 1);
    chk("restart_pat",  {28'd0, a4, b4, c4, d4}, 0);
    for (int j = 1; j < 5; j++) @(negedge clk);
    chk("restart_pat1", {28'd0, a4, b4, c4, d4}, 1);

    // DIV=1: full sweep in 16 cycles, good gate.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      chk("d1_pat",  {28'd0, a1, b1, c1, d1}, j - 1);
      chk("d1_busy", {31'd0, busy1}, 1);
      chk("d1_done", {31'd0, done1}, 0);
      @(negedge clk);
    end
    chk("d1_end_done", {31'd0, done1}, 1);
    chk("d1_end_busy", {31'd0, busy1}, 0);
    chk("d1_end_err",  {24'd0, err1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
